// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer:
// register offsets, CTRL field positions, MODE codes and FSM states.
package timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Packs the CTRL fields into the 32-bit read-back word; unused bits read 0.
  function automatic logic [31:0] ctrl_word(input logic en, input logic [1:0] mode,
                                            input logic im);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN] = en;
    w[CTRL_MODE_HI:CTRL_MODE_LO] = mode;
    w[CTRL_IM] = im;
    return w;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Peripheral-bus port between the bridge (master) and the timer (slave).
interface timer_counter_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [3:0]  be;
  logic [31:0] rd;
  logic        irq;

  modport master (output addr, output we, output wd, output be,
                  input  rd,   input  irq);
  modport slave  (input  addr, input  we, input  wd, input  be,
                  output rd,   output irq);
endinterface

// File: rtl/timer_counter.sv
// 32-bit down-counting timer with CTRL/PRESET/COUNT registers and an
// interrupt line; one-shot (sticky IRQ) or auto-reload (one-cycle pulse).
module timer_counter
  import timer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  state_t      state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic        irqf;
  logic [31:0] preset;
  logic [31:0] count;

  logic        wr_full;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en_eff;

  always_comb begin
    wr_full   = bus.we && (bus.be == BE_WORD);
    wr_ctrl   = wr_full && (bus.addr == REG_CTRL);
    wr_preset = wr_full && (bus.addr == REG_PRESET);
    // The FSM follows the EN value that will be in CTRL after this edge.
    en_eff    = wr_ctrl ? bus.wd[CTRL_EN] : en;
  end

  always_comb begin
    bus.rd = '0;
    case (bus.addr)
      REG_CTRL:   bus.rd = ctrl_word(en, mode, im);
      REG_PRESET: bus.rd = preset;
      REG_COUNT:  bus.rd = count;
      REG_RSVD:   bus.rd = '0;
      default:    bus.rd = '0;
    endcase
  end

  assign bus.irq = im & ((state == ST_INT) | irqf);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      en     <= 1'b0;
      mode   <= MODE_ONESHOT;
      im     <= 1'b0;
      irqf   <= 1'b0;
      preset <= '0;
      count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en_eff) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (!en_eff) begin
            state <= ST_IDLE;
          end else begin
            count <= preset;
            state <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (!en_eff) begin
            state <= ST_IDLE;
          end else if (count <= 32'd1) begin
            count <= '0;
            state <= ST_INT;
          end else begin
            count <= count - 32'd1;
          end
        end
        ST_INT: begin
          if (!en_eff) begin
            state <= ST_IDLE;
          end else if (mode == MODE_RELOAD) begin
            state <= ST_LOAD;
          end else begin
            en    <= 1'b0;
            irqf  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (wr_preset) preset <= bus.wd;

      // Placed after the FSM so a CPU CTRL write overrides the one-shot EN
      // clear and IRQF set scheduled on the same edge.
      if (wr_ctrl) begin
        en   <= bus.wd[CTRL_EN];
        mode <= bus.wd[CTRL_MODE_HI:CTRL_MODE_LO];
        im   <= bus.wd[CTRL_IM];
        irqf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: period-position reference model,
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_timer_counter;

  logic clk;
  logic reset;
  timer_counter_if bus ();

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  logic chk_on;

  // Reference model: the timer is either inactive (COUNT holds m_held) or
  // active at position m_pos within a period of length max(P,1)+2, where
  // position 0 is the load cycle and position max(P,1)+1 is the interrupt.
  logic        m_en, m_im, m_irqf, m_act;
  logic [1:0]  m_mode;
  logic [31:0] m_pre, m_pl, m_held;
  int unsigned m_pos;

  function automatic int unsigned m_len();
    return (m_pl == 32'd0) ? 1 : int'(m_pl);
  endfunction

  function automatic logic [31:0] m_cnt();
    if (!m_act || m_pos == 0) return m_held;
    if (m_pos > m_len()) return 32'd0;
    return m_pl - 32'(m_pos - 1);
  endfunction

  function automatic logic m_in_int();
    return m_act && (m_pos == m_len() + 1);
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] a);
    logic [31:0] w;
    w = 32'd0;
    case (a)
      2'd0: begin w[0] = m_en; w[2:1] = m_mode; w[3] = m_im; end
      2'd1: w = m_pre;
      2'd2: w = m_cnt();
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  function automatic logic m_irq();
    return m_im & (m_in_int() | m_irqf);
  endfunction

  task automatic model_step(input logic r, input logic w, input logic [1:0] a,
                            input logic [31:0] d, input logic [3:0] b);
    logic wc, wp, en_eff;
    logic [31:0] cur;
    if (r) begin
      m_en = 0; m_im = 0; m_irqf = 0; m_act = 0; m_mode = 0;
      m_pre = 0; m_pl = 0; m_held = 0; m_pos = 0;
      return;
    end
    wc = w && (b == 4'hF) && (a == 2'd0);
    wp = w && (b == 4'hF) && (a == 2'd1);
    en_eff = wc ? d[0] : m_en;
    cur = m_cnt();
    if (!m_act) begin
      if (en_eff) begin m_act = 1; m_pos = 0; end
    end else if (!en_eff) begin
      m_act = 0; m_held = cur;
    end else if (m_pos == 0) begin
      m_pl = m_pre; m_pos = 1;
    end else if (m_pos <= m_len()) begin
      m_pos = m_pos + 1;
    end else if (m_mode == 2'd1) begin
      m_pos = 0; m_held = 32'd0;
    end else begin
      m_act = 0; m_held = 32'd0; m_en = 0; m_irqf = 1;
    end
    if (wp) m_pre = d;
    if (wc) begin
      m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_irqf = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if (bus.rd !== m_rd(bus.addr)) begin
        bad++;
        $display("FAIL model_rd addr=%0d got=%h exp=%h t=%0t", bus.addr, bus.rd,
                 m_rd(bus.addr), $time);
      end
      total++;
      if (bus.irq !== m_irq()) begin
        bad++;
        $display("FAIL model_irq got=%b exp=%b t=%0t", bus.irq, m_irq(), $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [1:0] a,
                      input logic [31:0] d, input logic [3:0] b);
    reset   = r;
    bus.we  = w;
    bus.addr = a;
    bus.wd  = d;
    bus.be  = b;
    @(posedge clk);
    model_step(r, w, a, d, b);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d, 4'hF);
  endtask

  task automatic idle(input logic [1:0] a);
    step(1'b0, 1'b0, a, 32'd0, 4'h0);
  endtask

  initial begin
    total = 0; bad = 0; chk_on = 0;
    reset = 1'b1;
    bus.we = 1'b0; bus.addr = 2'd0; bus.wd = '0; bus.be = 4'h0;
    step(1'b1, 1'b0, 2'd0, 32'd0, 4'h0);
    step(1'b1, 1'b0, 2'd0, 32'd0, 4'h0);
    chk_on = 1;

    // Reset state and partial-byte write rejection
    for (int a = 0; a < 4; a++) begin
      idle(2'(a));
      chk("reset_rd", bus.rd, 32'd0);
    end
    chk("reset_irq", {31'd0, bus.irq}, 32'd0);
    step(1'b0, 1'b1, 2'd1, 32'h0000_0010, 4'b0011);
    idle(2'd1);
    chk("partial_be", bus.rd, 32'd0);

    // One-shot, PRESET=3, IM=1
    wr(2'd1, 32'd3);
    wr(2'd0, 32'b1001);
    for (int k = 1; k <= 4; k++) begin
      idle(2'd2);
      chk("oneshot_count", bus.rd, 32'(4 - k));
      if (k < 4) chk("oneshot_irq_low", {31'd0, bus.irq}, 32'd0);
    end
    chk("oneshot_irq_rise", {31'd0, bus.irq}, 32'd1);
    idle(2'd0); idle(2'd0);
    chk("oneshot_irq_sticky", {31'd0, bus.irq}, 32'd1);
    chk("oneshot_ctrl", bus.rd, 32'b1000);
    wr(2'd0, 32'd0);
    chk("oneshot_irq_clear", {31'd0, bus.irq}, 32'd0);

    // Auto-reload, PRESET=2: pulse every 4 cycles
    wr(2'd1, 32'd2);
    wr(2'd0, 32'b1011);
    for (int k = 1; k <= 12; k++) begin
      idle(2'd2);
      chk("reload_irq", {31'd0, bus.irq}, (k % 4 == 3) ? 32'd1 : 32'd0);
      case (k % 4)
        1: chk("reload_count", bus.rd, 32'd2);
        2: chk("reload_count", bus.rd, 32'd1);
        default: chk("reload_count", bus.rd, 32'd0);
      endcase
    end
    wr(2'd0, 32'd0);

    // One-shot with interrupt masked
    wr(2'd1, 32'd100);
    wr(2'd0, 32'b0001);
    for (int k = 0; k < 110; k++) idle(2'd0);
    chk("masked_irq", {31'd0, bus.irq}, 32'd0);
    chk("masked_en_clear", bus.rd, 32'd0);
    wr(2'd0, 32'b1000);
    chk("masked_unmask_irq", {31'd0, bus.irq}, 32'd0);

    // Disable mid-count
    wr(2'd1, 32'd10);
    wr(2'd0, 32'b1001);
    for (int k = 0; k < 5; k++) idle(2'd2);
    chk("disable_pre", bus.rd, 32'd6);
    wr(2'd0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      idle(2'd2);
      chk("disable_hold", bus.rd, 32'd6);
      chk("disable_irq", {31'd0, bus.irq}, 32'd0);
    end

    // CTRL write colliding with one-shot exit from INT
    wr(2'd1, 32'd2);
    wr(2'd0, 32'b1001);
    idle(2'd2); idle(2'd2); idle(2'd2);
    chk("collide_int", {31'd0, bus.irq}, 32'd1);
    wr(2'd0, 32'b0001);
    chk("collide_en", bus.rd, 32'b0001);
    idle(2'd2); idle(2'd2);
    chk("collide_reload", bus.rd, 32'd2);

    // Reset during CNT with a simultaneous write
    wr(2'd1, 32'd50);
    wr(2'd0, 32'b1001);
    for (int k = 0; k < 5; k++) idle(2'd2);
    step(1'b1, 1'b1, 2'd1, 32'd123, 4'hF);
    for (int a = 0; a < 3; a++) begin
      idle(2'(a));
      chk("midreset_rd", bus.rd, 32'd0);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic r, w;
      logic [1:0] a;
      logic [31:0] d;
      logic [3:0] b;
      r = ($urandom_range(0, 399) == 0);
      w = ($urandom_range(0, 2) == 0);
      a = 2'($urandom_range(0, 3));
      b = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      d = 32'($urandom_range(0, 15));
      if (a == 2'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      step(r, w, a, d, b);
    end

    idle(2'd0);
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counting timer on the processor's peripheral bus: the responder end of the Pr* bridge port driven by the memory stage. It decodes word reads and writes to three registers (CTRL, PRESET, COUNT), counts down from PRESET, and raises an interrupt line that the bridge routes onto one HWInt bit of CP0.

## Interface
- (no parameters)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; polarity and synchronicity fixed
- addr  in  2  word offset within the device window, i.e. PrAddr[3:2]
- we  in  1  write strobe, already gated by the bridge's device select and the stage's exception/interrupt disable
- wd  in  32  write data, i.e. PrWD
- be  in  4  byte enables, i.e. PrBE
- rd  out  32  read data; combinational from addr
- irq  out  1  interrupt request to HWInt

## Operation
- Register map:
  - addr 0 CTRL: [0] EN, [2:1] MODE, [3] IM; other bits read 0.
  - addr 1 PRESET: R/W 32-bit.
  - addr 2 COUNT: read-only.
  - addr 3: reads 0, writes ignored.
- Writes take effect only when we=1 and be=4'b1111. Partial-byte writes are ignored entirely.
- Writes to COUNT are ignored.
- MODE encoding:
  - 0: one-shot.
  - 1: auto-reload.
  - 2 and 3 behave as 0.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: go to LOAD when EN=1.
  - LOAD: COUNT←PRESET; go to CNT.
  - CNT: if EN=0, go to IDLE and hold COUNT. Else if COUNT≤1, COUNT←0 and go to INT. Else COUNT←COUNT−1.
  - INT, MODE 0: clear EN, set sticky flag IRQF, go to IDLE.
  - INT, MODE 1: go to LOAD.
- irq = IM & ((state==INT) | IRQF):
  - MODE 0 holds irq until software writes CTRL.
  - MODE 1 gives a one-cycle pulse per period.
- Any accepted CTRL write clears IRQF.
- Simultaneous CPU CTRL write and FSM EN-clear in INT: the CPU-written value wins.
- A PRESET write during CNT does not affect the running count; it is used at the next LOAD.
- A CTRL write with EN=0 during LOAD/CNT/INT returns the FSM to IDLE on the next edge. COUNT is held; IRQF is cleared.
- Arithmetic is unsigned 32-bit. PRESET=0 behaves as PRESET=1, so the counter never wraps below 0.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, IRQF=0, state=IDLE, irq=0. rd is 0 at all addresses.
- Register writes are visible on rd the cycle after the write edge.
- With an EN=1 CTRL write at edge 0 and PRESET=P:
  - LOAD during cycle after edge 0.
  - CNT for max(P,1) cycles.
  - INT for 1 cycle, starting at edge max(P,1)+1.
- irq rises combinationally with entry to INT, i.e. max(P,1)+1 edges after the enable write.
- MODE 1 period is max(P,1)+2 cycles: irq high for exactly 1 of them.
- Reset asserted mid-count overrides everything on that edge. An accepted write on the same edge is discarded.

## Structure
- Shared package timer_pkg:
  - register offsets (CTRL=0, PRESET=1, COUNT=2)
  - CTRL bit positions
  - MODE codes
  - FSM state encoding
- Single flat module; no sub-module needed. Register file and FSM live in the same always block family.

## Test plan
- Reset → rd=0 at addr 0..3, irq=0. Then write PRESET=0x0000_0010 with be=4'b0011 → PRESET still reads 0.
- PRESET=3, CTRL=0b1001 (EN, MODE0, IM) at edge 0:
  - COUNT reads 3, 2, 1, 0 after edges 1..4.
  - irq rises after edge 4 and stays high.
  - CTRL reads 0b1000.
  - Writing CTRL=0 drops irq next cycle.
- PRESET=2, CTRL=0b1011 (MODE1): irq is a 1-cycle pulse every 4 cycles for ≥3 periods; COUNT reloads to 2 each period.
- PRESET=100, MODE0, IM=0: after expiry, irq stays 0 and CTRL.EN reads 0. Then set IM=1 with EN=0: IRQF is already cleared by that write, so irq stays 0.
- Disable mid-count: PRESET=10, enable, write CTRL=0 after COUNT reads 6 → COUNT holds 6, state IDLE, irq never asserts.
- Collision and reset:
  - CPU writes CTRL=0b0001 on the same edge the one-shot FSM leaves INT → EN reads 1 and a new LOAD follows.
  - reset during CNT → all registers read 0 next cycle.
